// File: rtl/sigma_delta_decimator.sv
// Second-order CIC (sinc2) decimator for a 1-bit sigma-delta stream, with a
// single-entry valid/ready output register and a sticky overrun flag.
module sigma_delta_decimator #(
  parameter int N     = 10,
  parameter int DECIM = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         bit_en,
  output logic [N-1:0] sample_out,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         overrun
);

  localparam int PW = $clog2(DECIM);
  localparam int W  = 2 * PW;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

  logic [W:0]    int1_q, int1_d;
  logic [W:0]    int2_q, int2_d;
  logic [W:0]    int2_prev_q, int2_prev_d;
  logic [W:0]    c1_prev_q, c1_prev_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          warm_q, warm_d;
  logic [N-1:0]  sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  logic [W:0]    int1_acc, int2_acc, c1, c2;
  logic [W-1:0]  clipped;
  logic          dec_event, new_sample;
  logic          unused_clip_bits;

  always_comb begin
    int1_d      = int1_q;
    int2_d      = int2_q;
    int2_prev_d = int2_prev_q;
    c1_prev_d   = c1_prev_q;
    phase_d     = phase_q;
    warm_d      = warm_q;
    sample_d    = sample_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    // Combs see the integrator value that already includes the current bit.
    int1_acc   = int1_q + {{W{1'b0}}, bit_in};
    int2_acc   = int2_q + int1_acc;
    c1         = int2_acc - int2_prev_q;
    c2         = c1 - c1_prev_q;
    clipped    = c2[W] ? {W{1'b1}} : c2[W-1:0];
    dec_event  = bit_en && (phase_q == PHASE_LAST);
    new_sample = dec_event && warm_q;

    if (bit_en) begin
      int1_d  = int1_acc;
      int2_d  = int2_acc;
      phase_d = phase_q + 1'b1;
    end

    if (dec_event) begin
      int2_prev_d = int2_acc;
      c1_prev_d   = c1;
      warm_d      = 1'b1;
    end

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (new_sample) begin
      if (!valid_q || sample_ready) begin
        sample_d = clipped[W-1 -: N];
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Fractional LSBs below the output width are discarded by truncation.
  assign unused_clip_bits = ^{clipped, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      int1_q      <= '0;
      int2_q      <= '0;
      int2_prev_q <= '0;
      c1_prev_q   <= '0;
      phase_q     <= '0;
      warm_q      <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      int1_q      <= int1_d;
      int2_q      <= int2_d;
      int2_prev_q <= int2_prev_d;
      c1_prev_q   <= c1_prev_d;
      phase_q     <= phase_d;
      warm_q      <= warm_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/sigma_delta_decimator.md
SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

Interface
REQ-001 Parameter N, default 10: output sample width in bits.
REQ-002 Parameter DECIM, default 64: decimation ratio; power of two, 4..1024; W = 2*log2(DECIM); N <= W required.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bit_in  input  1  sigma-delta bitstream input; 1 counts as 1, 0 counts as 0.
REQ-006 bit_en  input  1  bit strobe; bit_in is accepted only on cycles with bit_en=1.
REQ-007 sample_out  output  N  decimated unsigned sample.
REQ-008 sample_valid  output  1  sample_out holds an unconsumed sample.
REQ-009 sample_ready  input  1  consumer accepts sample_out when sample_valid=1 and sample_ready=1.
REQ-010 overrun  output  1  sticky flag; a computed sample was dropped.

Function
REQ-011 Filter SHALL be a 2nd-order CIC (sinc2): two integrators, decimate by DECIM, two combs; all internal registers W+1 bits, modulo 2^(W+1) (wrap permitted).
REQ-012 On each cycle with bit_en=1: int1 <= int1 + bit_in; int2 <= int2 + (int1 + bit_in). Integrators SHALL hold when bit_en=0.
REQ-013 Phase counter counts accepted bits 0..DECIM-1, wraps to 0; holds when bit_en=0.
REQ-014 On the accepted bit with phase = DECIM-1 (decimation event), combs SHALL use the int2 value that includes that bit: c1 = int2_new - int2_prev_dec; c2 = c1 - c1_prev_dec; int2_prev_dec and c1_prev_dec updated at the event.
REQ-015 Result c2 range 0..2^W; SHALL be clipped to 2^W - 1, then sample_out = clipped[W-1:W-N] (truncation, no rounding).
REQ-016 First decimation event after reset SHALL update comb history but SHALL NOT present a sample (warm-up); every later event produces a sample.
REQ-017 Latency: produced sample SHALL appear on sample_out with sample_valid=1 the cycle after the decimation-event cycle.
REQ-018 sample_out and sample_valid SHALL hold stable while sample_valid=1 and sample_ready=0.
REQ-019 Handshake accepted (valid & ready) with no new sample that cycle: sample_valid <= 0 next cycle.
REQ-020 New sample produced in same cycle as accepted handshake: new sample loads, sample_valid stays 1, overrun unchanged.
REQ-021 New sample produced while sample_valid=1 and sample_ready=0: new sample SHALL be dropped, held sample kept, overrun <= 1.
REQ-022 overrun SHALL remain 1 until reset.
REQ-023 sample_ready SHALL be ignored while sample_valid=0.

Reset
REQ-024 On reset=1 at a clock edge: int1, int2, comb history, phase counter, warm-up state cleared to 0; sample_out = 0, sample_valid = 0, overrun = 0 next cycle.
REQ-025 Reset SHALL take priority over bit_en and handshake in the same cycle; reset mid-frame discards the partial frame and restarts warm-up.

Verification
REQ-026 Defaults, bit_en=1 every cycle, bit_in=1 constant, sample_ready=1 -> first sample_valid one cycle after the 128th accepted bit, sample_out = 10'h3FF (c2 = 4096 clipped); 10'h3FF every 64 bits thereafter.
REQ-027 Defaults, bit_in constant 0 -> samples every 64 bits after warm-up, sample_out = 10'h000.
REQ-028 Defaults, bit_in alternating 1,0,... -> every presented sample = 10'h200 (c2 = 2048).
REQ-029 bit_en=1 every 4th cycle, bit_in=1 -> first sample one cycle after the 128th accepted bit (cycle ~512); integrators and phase verified frozen on bit_en=0 cycles.
REQ-030 sample_ready=0 held across two sample events -> first sample held unchanged, overrun=1 after the second event; then sample_ready=1 for one cycle -> sample_valid drops; overrun stays 1.
REQ-031 Reset asserted at phase 30 of a frame during constant-1 input -> all outputs 0 next cycle; next presented sample one cycle after 128 further accepted bits, value 10'h3FF.
